// File: rtl/cordic_chk_pkg.sv
// rtl/cordic_chk_pkg.sv - shared types, widths and the sqrt acceptance window for the checker
package cordic_chk_pkg;

  localparam int IN_W   = 32;
  localparam int OUT_W  = 17;
  localparam int DOUT_W = 24;
  localparam int FIFO_D = 64;
  localparam int TOL_D  = 1;
  // squares of (y +/- tol) need one extra root bit, hence 2*(OUT_W+1)
  localparam int SQ_W   = 2 * (OUT_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef logic [SQ_W-1:0] sq_t;

  typedef struct packed {
    sq_t lo;
    sq_t hi;
  } bounds_t;

  // x is accepted for result y when (y-tol)^2 <= x <= (y+tol+1)^2-1
  function automatic bounds_t sq_bounds(input logic [OUT_W-1:0] y, input int tol);
    logic [OUT_W:0] yw;
    logic [OUT_W:0] tw;
    logic [OUT_W:0] lo_root;
    logic [OUT_W:0] hi_root;
    bounds_t        b;
    yw      = {1'b0, y};
    tw      = tol[OUT_W:0];
    lo_root = (yw > tw) ? (yw - tw) : '0;
    hi_root = yw + tw + (OUT_W + 1)'(1);
    b.lo    = sq_t'(lo_root) * sq_t'(lo_root);
    b.hi    = sq_t'(hi_root) * sq_t'(hi_root) - SQ_W'(1);
    return b;
  endfunction

endpackage

// File: rtl/cordic_sqrt_checker_fifo.sv
// rtl/cordic_sqrt_checker_fifo.sv - single-clock first-word-fall-through FIFO of issued x values
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cordic_sqrt_checker.sv
// rtl/cordic_sqrt_checker.sv - stimulus generator and result checker for the CORDIC sqrt core
module cordic_sqrt_checker
  import cordic_chk_pkg::*;
#(
  parameter int IN_WIDTH   = IN_W,
  parameter int OUT_WIDTH  = OUT_W,
  parameter int DOUT_WIDTH = DOUT_W,
  parameter int FIFO_DEPTH = FIFO_D,
  parameter int TOL        = TOL_D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   x_start,
  input  logic [31:0]           num_samples,
  output logic [IN_WIDTH-1:0]   s_axis_cartesian_tdata,
  output logic                  s_axis_cartesian_tvalid,
  input  logic [DOUT_WIDTH-1:0] m_axis_dout_tdata,
  input  logic                  m_axis_dout_tvalid,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           pass_count,
  output logic [31:0]           err_count,
  output logic                  err_unexpected,
  output logic [IN_WIDTH-1:0]   first_err_x,
  output logic [OUT_WIDTH-1:0]  first_err_y
);

  state_t                state;
  logic [IN_WIDTH-1:0]   x_cur;
  logic [31:0]           remaining;
  logic                  run_start;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [IN_WIDTH-1:0]   fifo_head;
  logic [OUT_WIDTH-1:0]  dout_y;
  bounds_t               dout_bounds;
  logic                  s1_valid;
  logic [IN_WIDTH-1:0]   s1_x;
  logic [OUT_WIDTH-1:0]  s1_y;
  sq_t                   s1_lo;
  sq_t                   s1_hi;
  logic                  s1_pass;
  logic                  unused_dout_hi;

  assign run_start      = start && (state == IDLE || state == DONE);
  assign fifo_push      = (state == RUN) && (remaining != '0) && !fifo_full;
  assign fifo_pop       = m_axis_dout_tvalid && !fifo_empty;
  assign dout_y         = m_axis_dout_tdata[OUT_WIDTH-1:0];
  assign dout_bounds    = sq_bounds(dout_y, TOL);
  assign s1_pass        = (s1_lo <= sq_t'(s1_x)) && (sq_t'(s1_x) <= s1_hi);
  assign unused_dout_hi = ^m_axis_dout_tdata[DOUT_WIDTH-1:OUT_WIDTH];

  sync_fifo #(
    .WIDTH (IN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (x_cur),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // run sequencing: load on start, count down issues, wait for all results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      x_cur     <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            x_cur     <= x_start;
            remaining <= num_samples;
            if (num_samples == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (fifo_push) begin
            x_cur     <= x_cur + IN_WIDTH'(1);
            remaining <= remaining - 32'd1;
          end else if (remaining == '0) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty && !s1_valid) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // issue register: the beat pushed this cycle is presented to the core next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axis_cartesian_tvalid <= 1'b0;
      s_axis_cartesian_tdata  <= '0;
    end else begin
      s_axis_cartesian_tvalid <= fifo_push;
      if (fifo_push) s_axis_cartesian_tdata <= x_cur;
    end
  end

  // compare stage 1: pair the result with its x and precompute the acceptance window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_lo    <= '0;
      s1_hi    <= '0;
    end else begin
      s1_valid <= fifo_pop;
      if (fifo_pop) begin
        s1_x  <= fifo_head;
        s1_y  <= dout_y;
        s1_lo <= dout_bounds.lo;
        s1_hi <= dout_bounds.hi;
      end
    end
  end

  // compare stage 2: saturating pass/error counts and first-failure capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_count  <= '0;
      err_count   <= '0;
      first_err_x <= '0;
      first_err_y <= '0;
    end else if (run_start) begin
      pass_count  <= '0;
      err_count   <= '0;
      first_err_x <= '0;
      first_err_y <= '0;
    end else if (s1_valid) begin
      if (s1_pass) begin
        if (pass_count != '1) pass_count <= pass_count + 32'd1;
      end else begin
        if (err_count != '1) err_count <= err_count + 32'd1;
        if (err_count == '0) begin
          first_err_x <= s1_x;
          first_err_y <= s1_y;
        end
      end
    end
  end

  // sticky flag for results that have no matching issued x
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_unexpected <= 1'b0;
    end else if (m_axis_dout_tvalid && fifo_empty) begin
      err_unexpected <= 1'b1;
    end else if (run_start) begin
      err_unexpected <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cordic_sqrt_checker.sv
// tb/tb_cordic_sqrt_checker.sv - randomized self-checking bench with a behavioural sqrt core model
module tb_cordic_sqrt_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] x_start = '0;
  logic [31:0] num_samples = '0;
  logic [23:0] m_tdata = '0;
  logic        m_tvalid = 1'b0;
  logic        inj_tvalid = 1'b0;
  logic        dout_tvalid;

  logic [31:0] tdata0, tdata1, pass0, pass1, err0, err1, fx0, fx1;
  logic        tvalid0, tvalid1, busy0, busy1, done0, done1, eu0, eu1;
  logic [16:0] fy0, fy1;

  int checks = 0;
  int errors = 0;

  int          lat_g = 20;
  bit          rnd_g = 1'b0;
  bit          inj_g = 1'b0;
  longint      cyc = 0;
  longint      q_due[$];
  logic [16:0] q_y[$];
  int          iss0 = 0, iss1 = 0, seq0 = 0, seq1 = 0;
  logic [31:0] ex0 = '0, ex1 = '0;
  int          outst = 0, max_out = 0;
  bit          ret_now;

  assign dout_tvalid = m_tvalid | inj_tvalid;

  always #5 clk = ~clk;

  cordic_sqrt_checker #(.TOL(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .x_start(x_start), .num_samples(num_samples),
    .s_axis_cartesian_tdata(tdata0), .s_axis_cartesian_tvalid(tvalid0),
    .m_axis_dout_tdata(m_tdata), .m_axis_dout_tvalid(dout_tvalid),
    .busy(busy0), .done(done0), .pass_count(pass0), .err_count(err0),
    .err_unexpected(eu0), .first_err_x(fx0), .first_err_y(fy0)
  );

  cordic_sqrt_checker #(.TOL(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .x_start(x_start), .num_samples(num_samples),
    .s_axis_cartesian_tdata(tdata1), .s_axis_cartesian_tvalid(tvalid1),
    .m_axis_dout_tdata(m_tdata), .m_axis_dout_tvalid(dout_tvalid),
    .busy(busy1), .done(done1), .pass_count(pass1), .err_count(err1),
    .err_unexpected(eu1), .first_err_x(fx1), .first_err_y(fy1)
  );

  function automatic longint isqrt(input logic [31:0] x);
    longint lo, hi, mid;
    lo = 0;
    hi = 65536;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(x)) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  function automatic logic [16:0] core_y(input logic [31:0] x, input bit rn, input bit ij);
    longint f;
    f = isqrt(x);
    if (rn && (longint'(x) - f * f > f)) f = f + 1;
    if (ij && x == 32'd24) f = 5;
    return f[16:0];
  endfunction

  // sqrt core model plus issue monitor, both on the falling edge
  always @(negedge clk) begin : core_model
    cyc <= cyc + 1;
    ret_now = 1'b0;
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      m_tvalid <= 1'b1;
      m_tdata  <= {7'($urandom), q_y.pop_front()};
      void'(q_due.pop_front());
      ret_now = 1'b1;
    end else begin
      m_tvalid <= 1'b0;
    end
    if (tvalid0) begin
      q_due.push_back(cyc + longint'(lat_g));
      q_y.push_back(core_y(tdata0, rnd_g, inj_g));
    end
    outst <= outst + (tvalid0 ? 1 : 0) - (ret_now ? 1 : 0);
    if (start) begin
      iss0 <= 0; iss1 <= 0; seq0 <= 0; seq1 <= 0;
      ex0 <= x_start; ex1 <= x_start; max_out <= 0;
    end else begin
      if (tvalid0) begin
        iss0 <= iss0 + 1;
        if (tdata0 !== ex0) seq0 <= seq0 + 1;
        ex0 <= ex0 + 32'd1;
      end
      if (tvalid1) begin
        iss1 <= iss1 + 1;
        if (tdata1 !== ex1) seq1 <= seq1 + 1;
        ex1 <= ex1 + 32'd1;
      end
      if (outst > max_out) max_out <= outst;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_run(input string nm, input logic [31:0] xs, input int n, input int l,
                        input bit rn, input bit ij);
    int ep0 = 0, ee0 = 0, ep1 = 0, ee1 = 0;
    logic [31:0] efx0 = '0, efx1 = '0, x;
    logic [16:0] efy0 = '0, efy1 = '0, y;
    longint d;
    bit fin = 1'b0;
    lat_g = l; rnd_g = rn; inj_g = ij;
    for (int k = 0; k < n; k++) begin
      x = xs + 32'(k);
      y = core_y(x, rn, ij);
      d = longint'(y) - isqrt(x);
      if (d < 0) d = -d;
      if (d <= 0) ep0++;
      else begin
        if (ee0 == 0) begin efx0 = x; efy0 = y; end
        ee0++;
      end
      if (d <= 1) ep1++;
      else begin
        if (ee1 == 0) begin efx1 = x; efy1 = y; end
        ee1++;
      end
    end
    tick();
    x_start = xs; num_samples = 32'(n); start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      tick();
      if (done0 && done1) begin fin = 1'b1; break; end
    end
    checks++;
    if (!fin) begin errors++; $display("FAIL %s timeout done0=%0b done1=%0b exp 1", nm, done0, done1); end
    checks++;
    if ({busy0, busy1} !== 2'b00) begin errors++; $display("FAIL %s busy got %b exp 00", nm, {busy0, busy1}); end
    checks++;
    if (iss0 != n || iss1 != n) begin errors++; $display("FAIL %s beats got %0d/%0d exp %0d", nm, iss0, iss1, n); end
    checks++;
    if (seq0 != 0 || seq1 != 0) begin errors++; $display("FAIL %s x sequence bad beats %0d/%0d exp 0", nm, seq0, seq1); end
    checks++;
    if (pass0 !== 32'(ep0)) begin errors++; $display("FAIL %s dut0 pass_count got %0d exp %0d", nm, pass0, ep0); end
    checks++;
    if (err0 !== 32'(ee0)) begin errors++; $display("FAIL %s dut0 err_count got %0d exp %0d", nm, err0, ee0); end
    checks++;
    if (pass1 !== 32'(ep1)) begin errors++; $display("FAIL %s dut1 pass_count got %0d exp %0d", nm, pass1, ep1); end
    checks++;
    if (err1 !== 32'(ee1)) begin errors++; $display("FAIL %s dut1 err_count got %0d exp %0d", nm, err1, ee1); end
    checks++;
    if ({eu0, eu1} !== 2'b00) begin errors++; $display("FAIL %s err_unexpected got %b exp 00", nm, {eu0, eu1}); end
    if (ee0 > 0) begin
      checks++;
      if (fx0 !== efx0 || fy0 !== efy0) begin
        errors++; $display("FAIL %s dut0 first_err got %h/%h exp %h/%h", nm, fx0, fy0, efx0, efy0);
      end
    end
    if (ee1 > 0) begin
      checks++;
      if (fx1 !== efx1 || fy1 !== efy1) begin
        errors++; $display("FAIL %s dut1 first_err got %h/%h exp %h/%h", nm, fx1, fy1, efx1, efy1);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({tvalid0, busy0, done0, eu0, tvalid1, busy1, done1, eu1} !== 8'h00 ||
        pass0 !== '0 || err0 !== '0 || tdata0 !== '0 || fx0 !== '0 || fy0 !== '0) begin
      errors++;
      $display("FAIL reset outputs got tv=%b busy=%b done=%b eu=%b pass=%0d err=%0d exp all 0",
               tvalid0, busy0, done0, eu0, pass0, err0);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unexpected;
    tick();
    inj_tvalid = 1'b1;
    tick();
    inj_tvalid = 1'b0;
    repeat (3) tick();
    checks++;
    if ({eu0, eu1} !== 2'b11) begin errors++; $display("FAIL unexpected flag got %b exp 11", {eu0, eu1}); end
    checks++;
    if (pass0 !== '0 || err0 !== '0 || pass1 !== '0 || err1 !== '0) begin
      errors++; $display("FAIL unexpected counters got %0d/%0d exp 0/0", pass0, err0);
    end
  endtask

  task automatic test_backpressure;
    do_run("backpressure", 32'd1000, 200, 70, 1'b0, 1'b0);
    checks++;
    if (max_out != 64) begin errors++; $display("FAIL backpressure max outstanding got %0d exp 64", max_out); end
  endtask

  task automatic test_reset_mid;
    lat_g = 10; rnd_g = 1'b0; inj_g = 1'b0;
    tick();
    x_start = 32'd5000; num_samples = 32'd40; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL reset_mid pre busy got %b exp 1", busy0); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({tvalid0, busy0, done0, eu0, tvalid1, busy1, done1, eu1} !== 8'h00 ||
        pass0 !== '0 || err0 !== '0 || tdata0 !== '0 || pass1 !== '0 || tdata1 !== '0) begin
      errors++;
      $display("FAIL reset_mid async outputs got tv=%b busy=%b pass=%0d tdata=%h exp all 0",
               tvalid0, busy0, pass0, tdata0);
    end
    repeat (2) tick();
    rst = 1'b0;
    repeat (40) tick();
    checks++;
    if ({eu0, eu1} !== 2'b11 || pass0 !== '0) begin
      errors++; $display("FAIL reset_mid late results got eu=%b pass=%0d exp 11/0", {eu0, eu1}, pass0);
    end
    do_run("reset_restart", 32'd777, 8, 10, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 4; i++) begin
      do_run("random", $urandom, int'($urandom_range(1, 40)), int'($urandom_range(1, 90)),
             bit'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_unexpected();
    do_run("basic", 32'd0, 16, 20, 1'b0, 1'b0);
    do_run("inject", 32'd10, 30, 20, 1'b0, 1'b1);
    test_backpressure();
    do_run("wrap", 32'hFFFF_FFFE, 4, 20, 1'b1, 1'b0);
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
